// File: rtl/game_flow_controller_pkg.sv
// Game flow controller shared definitions.
// Holds the phase-machine state encoding (GF_*), the default values of the
// controller parameters, and a small helper used to size the frame timer.
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        GF_IDLE      = 3'd0,
        GF_READY     = 3'd1,
        GF_RUNNING   = 3'd2,
        GF_DYING     = 3'd3,
        GF_LEVEL_UP  = 3'd4,
        GF_GAME_OVER = 3'd5
    } gf_state_t;

    localparam int C_LIVES_INI_DEF      = 3;
    localparam int C_MAX_LEVEL_DEF      = 15;
    localparam int C_READY_FRAMES_DEF   = 60;
    localparam int C_DEATH_FRAMES_DEF   = 90;
    localparam int C_LEVELUP_FRAMES_DEF = 45;
    localparam int C_FLASH_PERIOD_DEF   = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/game_flow_controller_frame_timer.sv
// Frame timer: counts frame ticks since the last clear.
// Ports:
//   i_Clk, i_Rst_L  clock, async active-low reset
//   i_Clear         synchronous clear (wins over tick)
//   i_Tick          one-cycle frame pulse
//   i_Limit         number of ticks the current phase lasts
//   o_Count         ticks counted since clear
//   o_Done          high on the tick that completes the limit (count == limit-1)
// o_Done deliberately does not depend on i_Clear: the clear is derived from the
// next-state decision, which itself uses o_Done.
module frame_timer #(
    parameter int W = 7
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Clear,
    input  logic         i_Tick,
    input  logic [W-1:0] i_Limit,
    output logic [W-1:0] o_Count,
    output logic         o_Done
);
    localparam logic [W-1:0] ONE = W'(1);

    assign o_Done = i_Tick && (o_Count == (i_Limit - ONE));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)     o_Count <= '0;
        else if (i_Clear) o_Count <= '0;
        else if (i_Tick)  o_Count <= o_Count + ONE;
    end

endmodule

// File: rtl/game_flow_controller.sv
// Game flow controller: frame-timed phase machine
// IDLE -> READY -> RUNNING -> (DYING | LEVEL_UP) -> ... -> GAME_OVER -> IDLE.
// Owns the lives and level counters and drives the gameplay control signals.
// Ports:
//   i_Clk, i_Rst_L    clock, async active-low reset
//   i_Frame_Tick      one-cycle pulse per frame
//   i_Start           debounced start level (acts on its rising edge)
//   i_Has_Collided    collision level, used only in RUNNING
//   i_Level_Up        goal-reached pulse, used only in RUNNING
//   o_Game_Active     frog input enabled (RUNNING)
//   o_Freeze          obstacles halted (every state but RUNNING)
//   o_Flash           frog blink enable (DYING only)
//   o_Frog_Reset      one-cycle pulse returning the frog to base
//   o_Lives, o_Level  counters
//   o_Game_Over       high in GAME_OVER
//   o_State           current state encoding
// The 1-bit outputs are registered from the next-state decode so they line up
// with o_State and read 0 during reset.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int C_LIVES_INI      = C_LIVES_INI_DEF,
    parameter int C_MAX_LEVEL      = C_MAX_LEVEL_DEF,
    parameter int C_READY_FRAMES   = C_READY_FRAMES_DEF,
    parameter int C_DEATH_FRAMES   = C_DEATH_FRAMES_DEF,
    parameter int C_LEVELUP_FRAMES = C_LEVELUP_FRAMES_DEF,
    parameter int C_FLASH_PERIOD   = C_FLASH_PERIOD_DEF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    output logic       o_Game_Active,
    output logic       o_Freeze,
    output logic       o_Flash,
    output logic       o_Frog_Reset,
    output logic [2:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);
    localparam int TW = $clog2(max3(C_READY_FRAMES, C_DEATH_FRAMES, C_LEVELUP_FRAMES) + 1);
    localparam logic [TW-1:0] READY_LIM   = TW'(C_READY_FRAMES);
    localparam logic [TW-1:0] DEATH_LIM   = TW'(C_DEATH_FRAMES);
    localparam logic [TW-1:0] LEVELUP_LIM = TW'(C_LEVELUP_FRAMES);
    localparam logic [2:0]    LIVES_INI   = 3'(C_LIVES_INI);
    localparam logic [3:0]    MAX_LEVEL   = 4'(C_MAX_LEVEL);

    gf_state_t     state, state_n;
    logic [2:0]    lives, lives_n;
    logic [3:0]    level, level_n;
    logic          flash, flash_n;
    logic          frog_n;
    logic          start_prev;
    logic          start_rise;
    logic          t_clear, t_done;
    logic [TW-1:0] t_limit, t_count;

    assign start_rise = i_Start & ~start_prev;

    frame_timer #(.W(TW)) u_timer (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clear (t_clear),
        .i_Tick  (i_Frame_Tick),
        .i_Limit (t_limit),
        .o_Count (t_count),
        .o_Done  (t_done)
    );

    always_comb begin
        state_n = state;
        lives_n = lives;
        level_n = level;
        flash_n = flash;
        frog_n  = 1'b0;
        t_limit = '0;
        case (state)
            GF_IDLE: if (start_rise) begin
                state_n = GF_READY;
                lives_n = LIVES_INI;
                level_n = '0;
                frog_n  = 1'b1;
            end
            GF_READY: begin
                t_limit = READY_LIM;
                if (t_done) state_n = GF_RUNNING;
            end
            GF_RUNNING: begin
                // Collision takes priority over a simultaneous level-up.
                if (i_Has_Collided) begin
                    state_n = GF_DYING;
                    lives_n = lives - 3'd1;
                    flash_n = 1'b1;
                end else if (i_Level_Up) begin
                    state_n = GF_LEVEL_UP;
                    level_n = (level >= MAX_LEVEL) ? level : level + 4'd1;
                end
            end
            GF_DYING: begin
                t_limit = DEATH_LIM;
                // Timer counts from 0 on entry, so the blink flips after every
                // C_FLASH_PERIOD-th tick.
                if (i_Frame_Tick && ((int'(t_count) + 1) % C_FLASH_PERIOD == 0))
                    flash_n = ~flash;
                if (t_done) begin
                    if (lives == 3'd0) begin
                        state_n = GF_GAME_OVER;
                    end else begin
                        state_n = GF_READY;
                        frog_n  = 1'b1;
                    end
                end
            end
            GF_LEVEL_UP: begin
                t_limit = LEVELUP_LIM;
                if (t_done) state_n = GF_RUNNING;
            end
            GF_GAME_OVER: if (start_rise) begin
                state_n = GF_IDLE;
                frog_n  = 1'b1;
            end
            default: state_n = GF_IDLE;
        endcase
    end

    assign t_clear = (state_n != state);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= GF_IDLE;
            lives         <= '0;
            level         <= '0;
            flash         <= 1'b0;
            start_prev    <= 1'b1;
            o_Game_Active <= 1'b0;
            o_Freeze      <= 1'b0;
            o_Flash       <= 1'b0;
            o_Frog_Reset  <= 1'b0;
            o_Game_Over   <= 1'b0;
        end else begin
            state         <= state_n;
            lives         <= lives_n;
            level         <= level_n;
            flash         <= flash_n;
            start_prev    <= i_Start;
            o_Game_Active <= (state_n == GF_RUNNING);
            o_Freeze      <= (state_n != GF_RUNNING);
            o_Flash       <= (state_n == GF_DYING) && flash_n;
            o_Frog_Reset  <= frog_n;
            o_Game_Over   <= (state_n == GF_GAME_OVER);
        end
    end

    assign o_Lives = lives;
    assign o_Level = level;
    assign o_State = state;

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;
    localparam int P_RDY = 2, P_DTH = 4, P_LU = 3, P_FL = 2, P_LIV = 2, P_MAX = 3;
    localparam int PH_IDLE = 0, PH_READY = 1, PH_RUN = 2, PH_DYING = 3, PH_LU = 4, PH_GO = 5;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, coll = 1'b0, lvl = 1'b0;
    logic       o_Game_Active, o_Freeze, o_Flash, o_Frog_Reset, o_Game_Over;
    logic [2:0] o_Lives, o_State;
    logic [3:0] o_Level;

    always #5 clk = ~clk;

    game_flow_controller #(
        .C_LIVES_INI(P_LIV), .C_MAX_LEVEL(P_MAX), .C_READY_FRAMES(P_RDY),
        .C_DEATH_FRAMES(P_DTH), .C_LEVELUP_FRAMES(P_LU), .C_FLASH_PERIOD(P_FL)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tick), .i_Start(start),
        .i_Has_Collided(coll), .i_Level_Up(lvl),
        .o_Game_Active(o_Game_Active), .o_Freeze(o_Freeze), .o_Flash(o_Flash),
        .o_Frog_Reset(o_Frog_Reset), .o_Lives(o_Lives), .o_Level(o_Level),
        .o_Game_Over(o_Game_Over), .o_State(o_State)
    );

    int n_vec = 0, n_err = 0;

    // Reference model: phase, counters and ticks elapsed in the current phase.
    int m_ph, m_lives, m_level, m_el;
    bit m_sp, m_fr, m_fresh;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_lives = 0; m_level = 0; m_el = 0;
        m_sp = 1'b1; m_fr = 1'b0; m_fresh = 1'b1;
    endtask

    task automatic model_step();
        bit rise;
        rise = start && !m_sp;
        m_sp = start;
        m_fr = 1'b0;
        m_fresh = 1'b0;
        case (m_ph)
            PH_IDLE: if (rise) begin
                m_ph = PH_READY; m_lives = P_LIV; m_level = 0; m_el = 0; m_fr = 1'b1;
            end
            PH_READY: if (tick) begin
                m_el++;
                if (m_el == P_RDY) begin m_ph = PH_RUN; m_el = 0; end
            end
            PH_RUN: begin
                if (coll) begin
                    m_ph = PH_DYING; m_lives--; m_el = 0;
                end else if (lvl) begin
                    m_ph = PH_LU; m_el = 0;
                    if (m_level < P_MAX) m_level++;
                end
            end
            PH_DYING: if (tick) begin
                m_el++;
                if (m_el == P_DTH) begin
                    m_el = 0;
                    if (m_lives == 0) m_ph = PH_GO;
                    else begin m_ph = PH_READY; m_fr = 1'b1; end
                end
            end
            PH_LU: if (tick) begin
                m_el++;
                if (m_el == P_LU) begin m_ph = PH_RUN; m_el = 0; end
            end
            PH_GO: if (rise) begin m_ph = PH_IDLE; m_fr = 1'b1; end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    task automatic check_all(input string w);
        bit live;
        live = !m_fresh;
        chk({w, ".state"},  8'(o_State),       8'(m_ph));
        chk({w, ".lives"},  8'(o_Lives),       8'(m_lives));
        chk({w, ".level"},  8'(o_Level),       8'(m_level));
        chk({w, ".active"}, 8'(o_Game_Active), 8'(live && m_ph == PH_RUN));
        chk({w, ".freeze"}, 8'(o_Freeze),      8'(live && m_ph != PH_RUN));
        chk({w, ".gover"},  8'(o_Game_Over),   8'(live && m_ph == PH_GO));
        chk({w, ".flash"},  8'(o_Flash),       8'(live && m_ph == PH_DYING && ((m_el / P_FL) % 2 == 0)));
        chk({w, ".frogrst"}, 8'(o_Frog_Reset), 8'(m_fr));
    endtask

    task automatic cyc(input string w, input bit s, input bit c, input bit l, input bit t);
        start = s; coll = c; lvl = l; tick = t;
        @(posedge clk);
        model_step();
        #1 check_all(w);
    endtask

    // Async reset between edges: outputs must clear with no clock edge.
    task automatic mid_reset(input string w);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(w);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset with start held, then a real rising edge
        model_reset();
        start = 1'b1;
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) cyc("held", 1, 0, 0, 0);
        chk("held_idle", 8'(o_State), 8'd0);
        cyc("drop", 0, 0, 0, 0);
        cyc("rise", 1, 0, 0, 0);
        chk("rise_ready", 8'(o_State), 8'd1);
        chk("rise_lives", 8'(o_Lives), 8'd2);
        chk("rise_frogrst", 8'(o_Frog_Reset), 8'd1);
        cyc("ready", 1, 0, 0, 0);
        chk("frogrst_once", 8'(o_Frog_Reset), 8'd0);
        // 2: READY -> RUNNING -> LEVEL_UP -> RUNNING
        cyc("ready", 1, 0, 0, 1);
        cyc("ready", 1, 0, 0, 0);
        cyc("ready", 1, 0, 0, 1);
        chk("run_active", 8'(o_Game_Active), 8'd1);
        cyc("lvlup", 1, 0, 1, 0);
        chk("lvlup_state", 8'(o_State), 8'd4);
        chk("lvlup_level", 8'(o_Level), 8'd1);
        repeat (3) cyc("lu", 1, 0, 0, 1);
        chk("lu_back_run", 8'(o_State), 8'd2);
        chk("lu_no_frogrst", 8'(o_Frog_Reset), 8'd0);
        // 3: collision, flash 1,1,0,0, back to READY with frog reset
        cyc("coll", 0, 1, 0, 0);
        chk("coll_lives", 8'(o_Lives), 8'd1);
        chk("coll_flash0", 8'(o_Flash), 8'd1);
        cyc("dying", 0, 1, 0, 1);
        chk("flash1", 8'(o_Flash), 8'd1);
        cyc("dying", 0, 1, 0, 1);
        chk("flash2", 8'(o_Flash), 8'd0);
        cyc("dying", 0, 0, 0, 1);
        chk("flash3", 8'(o_Flash), 8'd0);
        cyc("dying", 0, 0, 0, 1);
        chk("death_ready", 8'(o_State), 8'd1);
        chk("death_frogrst", 8'(o_Frog_Reset), 8'd1);
        repeat (2) cyc("ready", 0, 0, 0, 1);
        // 4: collision and level-up together
        cyc("both", 0, 1, 1, 0);
        chk("both_state", 8'(o_State), 8'd3);
        chk("both_level", 8'(o_Level), 8'd1);
        chk("both_lives", 8'(o_Lives), 8'd0);
        // 5: game over, collisions ignored, start back to IDLE
        repeat (4) cyc("dying", 0, 0, 0, 1);
        chk("go_state", 8'(o_State), 8'd5);
        chk("go_flag", 8'(o_Game_Over), 8'd1);
        repeat (3) cyc("go_coll", 0, 1, 1, 1);
        cyc("go_start", 1, 0, 0, 0);
        chk("go_idle", 8'(o_State), 8'd0);
        chk("go_frogrst", 8'(o_Frog_Reset), 8'd1);
        repeat (3) cyc("idle_coll", 1, 1, 1, 1);
        chk("idle_lives", 8'(o_Lives), 8'd0);
        // 6: async reset mid-DYING with timer at 2
        cyc("g2", 0, 0, 0, 0);
        cyc("g2", 1, 0, 0, 0);
        repeat (2) cyc("g2", 1, 0, 0, 1);
        cyc("g2", 1, 1, 0, 0);
        repeat (2) cyc("g2", 1, 0, 0, 1);
        mid_reset("midrst");
        chk("midrst_state", 8'(o_State), 8'd0);
        // randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            bit s;
            s = start;
            if ($urandom_range(0, 5) == 0) s = ~s;
            cyc("rand", s, $urandom_range(0, 14) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) mid_reset("rand_rst");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
